// File: rtl/bnn_conv3x3_xnor_if.sv
// Loader inputs, status flags and activation stream of the 3x3 XNOR conv stage.
// Optional macro BNN_SCORE_OUT_EN adds out_score, the raw popcount of each beat.
interface bnn_conv3x3_xnor_if #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned N_FILT  = 8
);
    localparam int unsigned OutDim = IMG_DIM - 2;
    localparam int unsigned FiltW  = (N_FILT > 1) ? $clog2(N_FILT) : 1;
    localparam int unsigned PosW   = $clog2(OutDim);

    logic                       start;
    logic [IMG_DIM*IMG_DIM-1:0] pixels_flat;
    logic [N_FILT*9-1:0]        weights_flat;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_bit;
    logic [FiltW-1:0]           out_filt;
    logic [PosW-1:0]            out_row;
    logic [PosW-1:0]            out_col;
    logic                       busy;
    logic                       done;
`ifdef BNN_SCORE_OUT_EN
    logic [3:0]                 out_score;
`endif

    // Loader / downstream side.
    modport master (
        output start, pixels_flat, weights_flat, out_ready,
        input  out_valid, out_bit, out_filt, out_row, out_col, busy, done
`ifdef BNN_SCORE_OUT_EN
        , input out_score
`endif
    );

    // Convolution stage side.
    modport slave (
        input  start, pixels_flat, weights_flat, out_ready,
        output out_valid, out_bit, out_filt, out_row, out_col, busy, done
`ifdef BNN_SCORE_OUT_EN
        , output out_score
`endif
    );
endinterface

// File: rtl/bnn_conv3x3_xnor.sv
// Binary 3x3 valid convolution: sweeps N_FILT filters over the image, XNOR-popcount per
// window, thresholds, and streams one activation per beat on a valid/ready output.
// Optional macro BNN_SCORE_OUT_EN also registers the raw popcount onto out_score.
module bnn_conv3x3_xnor #(
    parameter int unsigned IMG_DIM = 28,
    parameter int unsigned N_FILT  = 8,
    parameter int unsigned THRESH  = 5
) (
    input logic               clk,
    input logic               reset,
    bnn_conv3x3_xnor_if.slave bus
);
    localparam int unsigned OutDim = IMG_DIM - 2;
    localparam int unsigned FiltW  = (N_FILT > 1) ? $clog2(N_FILT) : 1;
    localparam int unsigned PosW   = $clog2(OutDim);
    localparam int unsigned PixW   = $clog2(IMG_DIM * IMG_DIM);
    localparam int unsigned WgtW   = $clog2(N_FILT * 9);
    localparam logic [FiltW-1:0] LastFilt = FiltW'(N_FILT - 1);
    localparam logic [PosW-1:0]  LastPos  = PosW'(OutDim - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [FiltW-1:0] f_q, f_d;
    logic [PosW-1:0]  r_q, r_d;
    logic [PosW-1:0]  c_q, c_d;
    logic             issued_q, issued_d;  // every beat has entered the output register
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic [FiltW-1:0] out_filt_q, out_filt_d;
    logic [PosW-1:0]  out_row_q, out_row_d;
    logic [PosW-1:0]  out_col_q, out_col_d;
`ifdef BNN_SCORE_OUT_EN
    logic [3:0]       score_q, score_d;
`endif

    logic [PixW-1:0]  pix_base;
    logic [WgtW-1:0]  wgt_base;
    logic [8:0]       win;
    logic [8:0]       wgt;
    logic [3:0]       pop;
    logic             act_bit;
    logic             out_free;
    logic             load;
    logic             last_issue;
    logic             last_hs;

    // Gather the window at (r,c), XNOR against filter f and threshold the match count.
    always_comb begin
        pix_base = PixW'(r_q) * PixW'(IMG_DIM) + PixW'(c_q);
        wgt_base = WgtW'(f_q) * WgtW'(9);
        win      = '0;
        wgt      = '0;
        pop      = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win[i*3+j] = bus.pixels_flat[pix_base + PixW'(i * IMG_DIM + j)];
                wgt[i*3+j] = bus.weights_flat[wgt_base + WgtW'(i * 3 + j)];
            end
        end
        for (int k = 0; k < 9; k++) begin
            pop = pop + {3'b000, ~(win[k] ^ wgt[k])};
        end
        act_bit = (pop >= 4'(THRESH));
    end

    // Handshake qualifiers for loading and for detecting the final beat leaving.
    always_comb begin
        out_free   = !out_valid_q || bus.out_ready;
        load       = (state_q == StRun) && !issued_q && out_free;
        last_issue = (f_q == LastFilt) && (r_q == LastPos) && (c_q == LastPos);
        last_hs    = out_valid_q && bus.out_ready && (out_filt_q == LastFilt) &&
                     (out_row_q == LastPos) && (out_col_q == LastPos);
    end

    // Next-state: FSM, issue counters and output register.
    always_comb begin
        state_d     = state_q;
        f_d         = f_q;
        r_d         = r_q;
        c_d         = c_q;
        issued_d    = issued_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_filt_d  = out_filt_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
`ifdef BNN_SCORE_OUT_EN
        score_d     = score_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StRun;
                    f_d      = '0;
                    r_d      = '0;
                    c_d      = '0;
                    issued_d = 1'b0;
                end
            end
            StRun: begin
                if (last_hs) state_d = StDone;
            end
            StDone: begin
                if (!bus.start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_bit_d   = act_bit;
            out_filt_d  = f_q;
            out_row_d   = r_q;
            out_col_d   = c_q;
`ifdef BNN_SCORE_OUT_EN
            score_d     = pop;
`endif
            if (last_issue) issued_d = 1'b1;
            // Column innermost, then row, then filter.
            if (c_q == LastPos) begin
                c_d = '0;
                if (r_q == LastPos) begin
                    r_d = '0;
                    f_d = (f_q == LastFilt) ? '0 : f_q + 1'b1;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end else begin
                c_d = c_q + 1'b1;
            end
        end else if (out_free) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            f_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            issued_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_filt_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
`ifdef BNN_SCORE_OUT_EN
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            r_q         <= r_d;
            c_q         <= c_d;
            issued_q    <= issued_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_filt_q  <= out_filt_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
`ifdef BNN_SCORE_OUT_EN
            score_q     <= score_d;
`endif
        end
    end

    // Drive the stream and status outputs.
    always_comb begin
        bus.out_valid = out_valid_q;
        bus.out_bit   = out_bit_q;
        bus.out_filt  = out_filt_q;
        bus.out_row   = out_row_q;
        bus.out_col   = out_col_q;
        bus.busy      = (state_q == StRun);
        bus.done      = (state_q == StDone);
`ifdef BNN_SCORE_OUT_EN
        bus.out_score = score_q;
`endif
    end
endmodule

// File: tb/tb_bnn_conv3x3_xnor.sv
// Scoreboard bench for bnn_conv3x3_xnor: a 2-D array model pushes every expected beat of a
// sweep into a queue; a negedge monitor pops and compares on each handshake.
`timescale 1ns/1ps
module tb_bnn_conv3x3_xnor;
    localparam int unsigned IMG_DIM = 28;
    localparam int unsigned N_FILT  = 8;
    localparam int unsigned THRESH  = 5;
    localparam int unsigned OUT_DIM = IMG_DIM - 2;
    localparam int unsigned BEATS   = N_FILT * OUT_DIM * OUT_DIM;

    typedef struct packed {
        logic       b;
        logic [2:0] f;
        logic [4:0] r;
        logic [4:0] c;
        logic [3:0] s;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bnn_conv3x3_xnor_if #(.IMG_DIM(IMG_DIM), .N_FILT(N_FILT)) bus ();

    bnn_conv3x3_xnor #(.IMG_DIM(IMG_DIM), .N_FILT(N_FILT), .THRESH(THRESH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    beat_t exp_q[$];
    bit    pix[IMG_DIM][IMG_DIM];
    bit    wgt[N_FILT][3][3];
    int    checks = 0;
    int    errors = 0;
    int    hs_total = 0;
    int    stall_total = 0;
    time   last_hs_t = 0;
    int    bp_at = -1;
    int    bp_left = 0;
    int    ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                case (kind)
                    0, 2:    pix[r][c] = 1'b1;
                    1:       pix[r][c] = bit'((r + c) % 2);
                    default: pix[r][c] = bit'($urandom_range(0, 1));
                endcase
        for (int f = 0; f < N_FILT; f++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    case (kind)
                        0:       wgt[f][i][j] = 1'b1;
                        1:       wgt[f][i][j] = 1'b0;
                        2:       wgt[f][i][j] = (f == 3);
                        default: wgt[f][i][j] = bit'($urandom_range(0, 1));
                    endcase
        for (int r = 0; r < IMG_DIM; r++)
            for (int c = 0; c < IMG_DIM; c++)
                bus.pixels_flat[r*IMG_DIM+c] = pix[r][c];
        for (int f = 0; f < N_FILT; f++)
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    bus.weights_flat[f*9+i*3+j] = wgt[f][i][j];
    endtask

    // Reference: count matching window/weight bits per position, in filter/row/col order.
    task automatic push_expected();
        beat_t e;
        int    pop;
        for (int f = 0; f < N_FILT; f++)
            for (int r = 0; r < OUT_DIM; r++)
                for (int c = 0; c < OUT_DIM; c++) begin
                    pop = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            if (pix[r+i][c+j] == wgt[f][i][j]) pop++;
                    e.b = (pop >= THRESH);
                    e.f = 3'(f);
                    e.r = 5'(r);
                    e.c = 5'(c);
`ifdef BNN_SCORE_OUT_EN
                    e.s = 4'(pop);
`else
                    e.s = 4'd0;
`endif
                    exp_q.push_back(e);
                end
    endtask

    // Monitor: compare on every handshake and confirm outputs hold while stalled.
    initial begin : monitor
        beat_t got;
        beat_t want;
        beat_t snap;
        bit    stalled;
        stalled = 1'b0;
        snap    = '0;
        forever begin
            @(negedge clk);
            got.b = bus.out_bit;
            got.f = bus.out_filt;
            got.r = bus.out_row;
            got.c = bus.out_col;
`ifdef BNN_SCORE_OUT_EN
            got.s = bus.out_score;
`else
            got.s = 4'd0;
`endif
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) check("hold_stable", 32'(got), 32'(snap));
                stalled = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat_unexpected: got %0h, expected no beat", got);
                        end else begin
                            want = exp_q.pop_front();
                            check("beat", 32'(got), 32'(want));
                        end
                        hs_total++;
                        last_hs_t = $time;
                    end else begin
                        snap    = got;
                        stalled = 1'b1;
                        stall_total++;
                    end
                end
            end
        end
    end

    // Downstream ready: always, random, or a forced stall window at a chosen beat.
    initial begin : ready_drv
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_left > 0 && hs_total == bp_at) begin
                bus.out_ready = 1'b0;
                bp_left--;
            end else if (ready_mode == 1) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < int'(BEATS) * 6) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done=%b, expected 1 within %0d cycles", bus.done, n);
            exp_q.delete();
            reset = 1'b1;
            #1;
            reset = 1'b0;
        end else begin
            check("done_one_edge_after_last_hs", 32'($time - last_hs_t), 32'd6);
            check("busy_low_in_done", 32'(bus.busy), 32'd0);
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic run_sweep(input bit drop_start);
        int base;
        base = hs_total;
        push_expected();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("edge1_busy", 32'(bus.busy), 32'd1);
        check("edge1_no_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("edge2_first_valid", 32'(bus.out_valid), 32'd1);
        if (drop_start) begin
            repeat (20) @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_done();
        check("beat_count", 32'(hs_total - base), 32'(BEATS));
        if (drop_start) begin
            @(posedge clk);
            #1;
            check("done_to_idle", 32'(bus.done), 32'd0);
        end else begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check("done_held", 32'(bus.done), 32'd1);
                check("no_valid_in_done", 32'(bus.out_valid), 32'd0);
            end
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            check("idle_done", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin : stim
        int base;
        int n;
        int stalls0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.pixels_flat  = '0;
        bus.weights_flat = '0;
        #3;
        check("rst_outputs", 32'({bus.out_valid, bus.out_bit, bus.out_filt, bus.out_row,
                                  bus.out_col, bus.busy, bus.done}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        fill(0);  // all ones
        run_sweep(1'b0);
        fill(1);  // checkerboard, zero weights
        run_sweep(1'b0);
        fill(2);  // only filter 3 set
        run_sweep(1'b0);
        fill(3);  // random data, random backpressure
        ready_mode = 1;
        run_sweep(1'b0);
        ready_mode = 0;

        // Ten-cycle stall while beat 3 is presented.
        fill(3);
        bp_at   = hs_total + 3;
        bp_left = 10;
        stalls0 = stall_total;
        run_sweep(1'b0);
        check("stall_cycles", 32'(stall_total - stalls0), 32'd10);

        // Reset in the middle of a sweep, then a fresh sweep from beat 0.
        fill(3);
        push_expected();
        base      = hs_total;
        bus.start = 1'b1;
        n         = 0;
        while (hs_total < base + 1000 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_beat_1000", 32'(hs_total >= base + 1000), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_fields", 32'({bus.out_bit, bus.out_filt, bus.out_row, bus.out_col}),
              32'd0);
        check("async_rst_status", 32'({bus.busy, bus.done}), 32'd0);
`ifdef BNN_SCORE_OUT_EN
        check("async_rst_score", 32'(bus.out_score), 32'd0);
`endif
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = hs_total;
        push_expected();
        wait_done();
        check("restart_beat_count", 32'(hs_total - base), 32'(BEATS));
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("restart_idle", 32'(bus.done), 32'd0);

        // start dropped during the sweep; the sweep still completes.
        fill(3);
        run_sweep(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
